// File: rtl/mem_port_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_pkg
// Shared definitions for the unified-memory port arbiter:
//   state_e      : arbiter FSM encoding (IDLE / ACCESS / DONE)
//   OWN_I/OWN_D  : owner encoding, 0 = instruction fetch, 1 = data
//   CNT_W        : width of the access wait counter (WAIT_CYCLES <= 15)
// -----------------------------------------------------------------------------
package mem_port_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_e;

   localparam logic OWN_I = 1'b0;
   localparam logic OWN_D = 1'b1;

   localparam int CNT_W = 4;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_if
// Bundles every non-clock signal of the arbiter: the fetch requester port
// (i_*), the data requester port (d_*), the memory macro port (mem_*) and
// the status outputs (busy, owner).
//   slave  : the arbiter's view
//   master : the requesters + memory model view (control unit, datapath,
//            memory macro, or a testbench)
//
// Handshake: a requester raises req with addr (and we/wdata) stable and
// holds req high until its ack. ack is a single-cycle pulse; rdata is valid
// in the ack cycle and holds until the next completion on that port. The
// arbiter samples req/addr/we/wdata only while idle; a req still high in
// the idle cycle after ack counts as a new request.
// -----------------------------------------------------------------------------
interface mem_port_arbiter_if #(
   parameter int AW = 32,
   parameter int DW = 64
);
   logic          i_req;
   logic [AW-1:0] i_addr;
   logic          i_ack;
   logic [DW-1:0] i_rdata;

   logic          d_req;
   logic          d_we;
   logic [AW-1:0] d_addr;
   logic [DW-1:0] d_wdata;
   logic          d_ack;
   logic [DW-1:0] d_rdata;

   logic          mem_cs;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;

   logic          busy;
   logic          owner;

   modport slave (
      input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
      output i_ack, i_rdata, d_ack, d_rdata,
      output mem_cs, mem_we, mem_addr, mem_wdata, busy, owner
   );

   modport master (
      output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
      input  i_ack, i_rdata, d_ack, d_rdata,
      input  mem_cs, mem_we, mem_addr, mem_wdata, busy, owner
   );

endinterface

// File: rtl/mem_port_arbiter_rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Two-input round-robin arbiter. Bit 0 is the fetch requester, bit 1 the
// data requester.
//   clock, reset : system clock, synchronous active-high reset
//   req[1:0]     : pending requests
//   update       : commit the current grant into last_grant
//   grant[1:0]   : one-hot (or zero) combinational grant
//   last_grant   : registered owner of the most recent committed grant;
//                  resets to data so that fetch wins the first tie
// -----------------------------------------------------------------------------
module rr_arb2
   import mem_port_arbiter_pkg::*;
(
   input  logic       clock,
   input  logic       reset,
   input  logic [1:0] req,
   input  logic       update,
   output logic [1:0] grant,
   output logic       last_grant
);

   logic last_grant_q;
   logic last_grant_d;

   always_comb begin
      grant = req;
      // On a tie, the requester that did not win last time goes next.
      if (req == 2'b11) begin
         grant = (last_grant_q == OWN_I) ? 2'b10 : 2'b01;
      end
   end

   always_comb begin
      last_grant_d = last_grant_q;
      if (update && (grant != 2'b00)) begin
         last_grant_d = grant[1];
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         last_grant_q <= OWN_D;
      end else begin
         last_grant_q <= last_grant_d;
      end
   end

   assign last_grant = last_grant_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares the single-ported unified memory between the instruction-fetch
// requester and the data (load/store) requester. Requests are arbitrated
// round-robin in IDLE; the winner's address/control is registered onto the
// memory port and held for WAIT_CYCLES cycles with mem_cs high, read data is
// captured on the last of those cycles, and the owner's ack pulses in DONE.
//   clock, reset : system clock, synchronous active-high reset
//   bus          : mem_port_arbiter_if.slave (requester, memory, status)
//   dbg_state    : current FSM state, for observation only
// A request sampled in IDLE at cycle T gives mem_cs for T+1..T+WAIT_CYCLES
// and ack at T+WAIT_CYCLES+1.
// -----------------------------------------------------------------------------
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int AW          = 32,
   parameter int DW          = 64,
   parameter int WAIT_CYCLES = 2
) (
   input  logic              clock,
   input  logic              reset,
   mem_port_arbiter_if.slave bus,
   output state_e            dbg_state
);

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WAIT_CYCLES - 1);

   state_e           state_q,     state_d;
   logic [CNT_W-1:0] cnt_q,       cnt_d;
   logic             owner_q,     owner_d;
   logic [AW-1:0]    mem_addr_q,  mem_addr_d;
   logic             mem_we_q,    mem_we_d;
   logic [DW-1:0]    mem_wdata_q, mem_wdata_d;
   logic [DW-1:0]    i_rdata_q,   i_rdata_d;
   logic [DW-1:0]    d_rdata_q,   d_rdata_d;

   logic [1:0] grant;
   logic       arb_update;
   // The arbiter keeps its own tie-break history; owner has a separate
   // reset value (fetch) so that copy is not needed here.
   logic       arb_last_grant_unused;

   // Grants are only committed while idle, so requests seen during an
   // access never disturb the round-robin order.
   assign arb_update = (state_q == IDLE);

   rr_arb2 u_arb (
      .clock      (clock),
      .reset      (reset),
      .req        ({bus.d_req, bus.i_req}),
      .update     (arb_update),
      .grant      (grant),
      .last_grant (arb_last_grant_unused)
   );

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      owner_d     = owner_q;
      mem_addr_d  = mem_addr_q;
      mem_we_d    = mem_we_q;
      mem_wdata_d = mem_wdata_q;
      i_rdata_d   = i_rdata_q;
      d_rdata_d   = d_rdata_q;

      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (grant[1]) begin
               state_d     = ACCESS;
               owner_d     = OWN_D;
               mem_addr_d  = bus.d_addr;
               mem_we_d    = bus.d_we;
               mem_wdata_d = bus.d_wdata;
            end else if (grant[0]) begin
               state_d     = ACCESS;
               owner_d     = OWN_I;
               mem_addr_d  = bus.i_addr;
               mem_we_d    = 1'b0;
               mem_wdata_d = '0;
            end
         end

         ACCESS: begin
            if (cnt_q == LAST_CNT) begin
               state_d  = DONE;
               cnt_d    = '0;
               mem_we_d = 1'b0;
               // Stores leave d_rdata untouched.
               if (owner_q == OWN_I) begin
                  i_rdata_d = bus.mem_rdata;
               end else if (!mem_we_q) begin
                  d_rdata_d = bus.mem_rdata;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         DONE: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         owner_q     <= OWN_I;
         mem_addr_q  <= '0;
         mem_we_q    <= 1'b0;
         mem_wdata_q <= '0;
         i_rdata_q   <= '0;
         d_rdata_q   <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         owner_q     <= owner_d;
         mem_addr_q  <= mem_addr_d;
         mem_we_q    <= mem_we_d;
         mem_wdata_q <= mem_wdata_d;
         i_rdata_q   <= i_rdata_d;
         d_rdata_q   <= d_rdata_d;
      end
   end

   assign bus.mem_cs    = (state_q == ACCESS);
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign bus.i_ack     = (state_q == DONE) && (owner_q == OWN_I);
   assign bus.d_ack     = (state_q == DONE) && (owner_q == OWN_D);
   assign bus.i_rdata   = i_rdata_q;
   assign bus.d_rdata   = d_rdata_q;
   assign bus.busy      = (state_q != IDLE);
   assign bus.owner     = owner_q;
   assign dbg_state     = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
// Bench for mem_port_arbiter: dut2 runs with WAIT_CYCLES=2, dut1 with
// WAIT_CYCLES=1. Single-request vectors come from a table; tie-breaking,
// reset mid-access and back-to-back fetches are hand-written sequences.
// Completions on dut2 are checked against an expected queue at each ack.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;
   import mem_port_arbiter_pkg::*;

   localparam int AW = 32;
   localparam int DW = 64;
   localparam int W2 = 2;
   localparam int W1 = 1;
   localparam int NV = 10;

   typedef struct {
      logic          i_req;
      logic          d_req;
      logic          d_we;
      logic          chg_addr;
      logic [AW-1:0] i_addr;
      logic [AW-1:0] d_addr;
      logic [DW-1:0] d_wdata;
      logic [DW-1:0] mem_rd;
      logic          exp_port;
      logic          exp_we;
      logic [AW-1:0] exp_addr;
      logic [DW-1:0] exp_wdata;
      logic [DW-1:0] exp_i_rd;
      logic [DW-1:0] exp_d_rd;
   } vec_t;

   // ---------------- clock / reset ----------------
   logic clock = 1'b0;
   logic reset = 1'b1;
   int   cyc   = 0;

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   int total = 0;
   int bad   = 0;

   logic [DW:0] exp_q[$];
   logic [DW:0] sb_e;
   vec_t        vecs[NV];
   state_e      dbg2;
   state_e      dbg1;

   mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus2();
   mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus1();

   mem_port_arbiter #(.AW(AW), .DW(DW), .WAIT_CYCLES(W2)) dut2 (
      .clock     (clock),
      .reset     (reset),
      .bus       (bus2),
      .dbg_state (dbg2)
   );

   mem_port_arbiter #(.AW(AW), .DW(DW), .WAIT_CYCLES(W1)) dut1 (
      .clock     (clock),
      .reset     (reset),
      .bus       (bus1),
      .dbg_state (dbg1)
   );

   // ---------------- helpers ----------------
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic clear_inputs();
      bus2.i_req = 1'b0; bus2.i_addr = '0; bus2.d_req = 1'b0; bus2.d_we = 1'b0;
      bus2.d_addr = '0; bus2.d_wdata = '0; bus2.mem_rdata = '0;
      bus1.i_req = 1'b0; bus1.i_addr = '0; bus1.d_req = 1'b0; bus1.d_we = 1'b0;
      bus1.d_addr = '0; bus1.d_wdata = '0; bus1.mem_rdata = '0;
   endtask

   task automatic do_reset();
      clear_inputs();
      reset = 1'b1;
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b0;
      exp_q.delete();
   endtask

   function automatic vec_t mk(input logic ir, input logic dr, input logic we, input logic chg,
                               input logic [AW-1:0] ia, input logic [AW-1:0] da,
                               input logic [DW-1:0] wd, input logic [DW-1:0] mr);
      vec_t v;
      v = '{default: '0};
      v.i_req = ir; v.d_req = dr; v.d_we = we; v.chg_addr = chg;
      v.i_addr = ia; v.d_addr = da; v.d_wdata = wd; v.mem_rd = mr;
      return v;
   endfunction

   // Expected memory-port values and rdata registers after one
   // single-requester access, given the rdata values held before it.
   function automatic vec_t fill_exp(input vec_t vi, input logic [DW-1:0] pi, input logic [DW-1:0] pd);
      vec_t v;
      v = vi;
      v.exp_port  = v.d_req;
      v.exp_we    = v.d_req & v.d_we;
      v.exp_addr  = v.d_req ? v.d_addr : v.i_addr;
      v.exp_wdata = v.d_req ? v.d_wdata : '0;
      v.exp_i_rd  = v.d_req ? pi : v.mem_rd;
      v.exp_d_rd  = (v.d_req && !v.d_we) ? v.mem_rd : pd;
      return v;
   endfunction

   // Enter at posedge+1 with dut2 idle; leave at posedge+1 back in IDLE.
   task automatic run_vec(input vec_t v);
      bus2.i_req = v.i_req; bus2.d_req = v.d_req; bus2.d_we = v.d_we;
      bus2.i_addr = v.i_addr; bus2.d_addr = v.d_addr; bus2.d_wdata = v.d_wdata;
      bus2.mem_rdata = v.mem_rd;
      exp_q.push_back({v.exp_port, (v.exp_port ? v.exp_d_rd : v.exp_i_rd)});
      @(posedge clock); #1;
      // Requests dropped right after the grant: the access must still finish.
      bus2.i_req = 1'b0; bus2.d_req = 1'b0;
      for (int c = 0; c < W2; c++) begin
         chk("access_cs",    64'(bus2.mem_cs), 64'd1);
         chk("access_addr",  64'(bus2.mem_addr), 64'(v.exp_addr));
         chk("access_we",    64'(bus2.mem_we), 64'(v.exp_we));
         chk("access_wdata", bus2.mem_wdata, v.exp_wdata);
         chk("access_owner", 64'(bus2.owner), 64'(v.exp_port));
         chk("access_state", 64'(dbg2), 64'(ACCESS));
         if (v.chg_addr && c == 0) begin
            bus2.i_addr  = v.i_addr ^ 32'h300;
            bus2.d_addr  = v.d_addr ^ 32'h300;
            bus2.d_wdata = ~v.d_wdata;
            bus2.d_we    = ~v.d_we;
         end
         @(posedge clock); #1;
      end
      chk("done_i_ack", 64'(bus2.i_ack), 64'(!v.exp_port));
      chk("done_d_ack", 64'(bus2.d_ack), 64'(v.exp_port));
      chk("done_cs",    64'(bus2.mem_cs), 64'd0);
      chk("done_we",    64'(bus2.mem_we), 64'd0);
      chk("done_state", 64'(dbg2), 64'(DONE));
      @(posedge clock); #1;
      chk("idle_state", 64'(dbg2), 64'(IDLE));
      chk("idle_busy",  64'(bus2.busy), 64'd0);
      chk("idle_acks",  64'({bus2.i_ack, bus2.d_ack}), 64'd0);
      chk("hold_i_rdata", bus2.i_rdata, v.exp_i_rd);
      chk("hold_d_rdata", bus2.d_rdata, v.exp_d_rd);
   endtask

   // ---------------- scoreboard (dut2 completions) ----------------
   always @(negedge clock) begin
      if (!reset) begin
         chk("ack_excl", 64'(bus2.i_ack & bus2.d_ack), 64'd0);
         if (bus2.i_ack || bus2.d_ack) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL ack_unexpected: i_ack=%0b d_ack=%0b with nothing pending (cycle %0d)",
                        bus2.i_ack, bus2.d_ack, cyc);
            end else begin
               sb_e = exp_q.pop_front();
               chk("sb_port", 64'(bus2.d_ack), 64'(sb_e[DW]));
               chk("sb_rdata", (sb_e[DW] ? bus2.d_rdata : bus2.i_rdata), sb_e[DW-1:0]);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running want finished");
      $fatal(1, "timeout");
   end

   // ---------------- main test ----------------
   initial begin
      logic [DW-1:0] mi;
      logic [DW-1:0] md;
      int            acks;
      int            last;
      vec_t          v;

      clear_inputs();
      repeat (3) @(posedge clock);
      #1;
      reset = 1'b0;

      // Reset state.
      chk("rst_state", 64'(dbg2), 64'(IDLE));
      chk("rst_outs",  64'({bus2.i_ack, bus2.d_ack, bus2.mem_cs, bus2.mem_we, bus2.busy, bus2.owner}), 64'd0);
      chk("rst_addr",  64'(bus2.mem_addr), 64'd0);
      chk("rst_wdata", bus2.mem_wdata, 64'd0);
      chk("rst_i_rd",  bus2.i_rdata, 64'd0);
      chk("rst_d_rd",  bus2.d_rdata, 64'd0);

      // Vector table: one requester at a time.
      vecs[0] = mk(1'b1, 1'b0, 1'b0, 1'b0, 32'h40,  32'h0,   64'h0,         64'hF800_0000_1234_5678);
      vecs[1] = mk(1'b0, 1'b1, 1'b0, 1'b0, 32'h0,   32'h80,  64'h0,         64'h1111_2222_3333_4444);
      vecs[2] = mk(1'b0, 1'b1, 1'b1, 1'b0, 32'h0,   32'h100, 64'hDEAD_BEEF, 64'hAAAA_AAAA_AAAA_AAAA);
      vecs[3] = mk(1'b0, 1'b1, 1'b0, 1'b1, 32'h0,   32'h100, 64'h0,         64'h5555_6666_7777_8888);
      vecs[4] = mk(1'b1, 1'b0, 1'b1, 1'b1, 32'h44,  32'h0,   64'hFFFF_FFFF, 64'h0123_4567_89AB_CDEF);
      for (int i = 5; i < NV; i++) begin
         logic p;
         p = 1'($urandom_range(0, 1));
         vecs[i] = mk(!p, p, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      $urandom, $urandom, {$urandom, $urandom}, {$urandom, $urandom});
      end
      mi = '0;
      md = '0;
      for (int i = 0; i < NV; i++) begin
         vecs[i] = fill_exp(vecs[i], mi, md);
         mi = vecs[i].exp_i_rd;
         md = vecs[i].exp_d_rd;
      end
      for (int i = 0; i < NV; i++) begin
         run_vec(vecs[i]);
      end
      chk("sb_drained_table", 64'(exp_q.size()), 64'd0);

      // Both requesters held from reset: fetch, data, fetch, data.
      do_reset();
      bus2.i_addr = 32'h10; bus2.d_addr = 32'h20; bus2.d_we = 1'b0;
      bus2.mem_rdata = 64'h0BAD_F00D_1357_9BDF;
      bus2.i_req = 1'b1; bus2.d_req = 1'b1;
      exp_q.push_back({OWN_I, 64'h0BAD_F00D_1357_9BDF});
      exp_q.push_back({OWN_D, 64'h0BAD_F00D_1357_9BDF});
      exp_q.push_back({OWN_I, 64'h0BAD_F00D_1357_9BDF});
      exp_q.push_back({OWN_D, 64'h0BAD_F00D_1357_9BDF});
      acks = 0;
      last = 0;
      for (int k = 0; k < 40 && acks < 4; k++) begin
         @(posedge clock); #1;
         if (bus2.i_ack || bus2.d_ack) begin
            if (acks > 0) chk("rr_spacing", 64'(cyc - last), 64'(W2 + 2));
            last = cyc;
            acks++;
            if (acks == 4) begin
               bus2.i_req = 1'b0;
               bus2.d_req = 1'b0;
            end
         end
      end
      chk("rr_ack_count", 64'(acks), 64'd4);
      @(posedge clock); #1;
      chk("rr_idle_busy", 64'(bus2.busy), 64'd0);
      chk("sb_drained_rr", 64'(exp_q.size()), 64'd0);

      // Reset in the first ACCESS cycle: no ack, rdata cleared.
      bus2.i_req = 1'b1; bus2.i_addr = 32'h80; bus2.mem_rdata = 64'h9999_9999_9999_9999;
      @(posedge clock); #1;
      chk("rma_cs_before", 64'(bus2.mem_cs), 64'd1);
      reset = 1'b1;
      bus2.i_req = 1'b0;
      @(posedge clock); #1;
      reset = 1'b0;
      chk("rma_cs",    64'(bus2.mem_cs), 64'd0);
      chk("rma_busy",  64'(bus2.busy), 64'd0);
      chk("rma_i_rd",  bus2.i_rdata, 64'd0);
      chk("rma_d_rd",  bus2.d_rdata, 64'd0);
      for (int k = 0; k < 4; k++) begin
         @(posedge clock); #1;
         chk("rma_no_ack", 64'({bus2.i_ack, bus2.d_ack}), 64'd0);
      end
      v = fill_exp(mk(1'b1, 1'b0, 1'b0, 1'b0, 32'h84, 32'h0, 64'h0, 64'h7777_0000_7777_0000),
                   64'd0, 64'd0);
      run_vec(v);

      // WAIT_CYCLES=1: back-to-back fetches, held req restarts after ack.
      bus1.i_req = 1'b1; bus1.i_addr = 32'h0; bus1.mem_rdata = 64'hCAFE_0000_0000_0001;
      @(posedge clock); #1;
      chk("w1_k1_cs",   64'(bus1.mem_cs), 64'd1);
      chk("w1_k1_addr", 64'(bus1.mem_addr), 64'h0);
      chk("w1_k1_we",   64'(bus1.mem_we), 64'd0);
      chk("w1_k1_ack",  64'(bus1.i_ack), 64'd0);
      bus1.i_addr = 32'h4;
      @(posedge clock); #1;
      chk("w1_k2_ack",  64'(bus1.i_ack), 64'd1);
      chk("w1_k2_cs",   64'(bus1.mem_cs), 64'd0);
      chk("w1_k2_rd",   bus1.i_rdata, 64'hCAFE_0000_0000_0001);
      bus1.mem_rdata = 64'hCAFE_0000_0000_0002;
      @(posedge clock); #1;
      chk("w1_k3_state", 64'(dbg1), 64'(IDLE));
      chk("w1_k3_ack",   64'(bus1.i_ack), 64'd0);
      chk("w1_k3_cs",    64'(bus1.mem_cs), 64'd0);
      @(posedge clock); #1;
      chk("w1_k4_cs",   64'(bus1.mem_cs), 64'd1);
      chk("w1_k4_addr", 64'(bus1.mem_addr), 64'h4);
      @(posedge clock); #1;
      chk("w1_k5_ack",  64'(bus1.i_ack), 64'd1);
      chk("w1_k5_rd",   bus1.i_rdata, 64'hCAFE_0000_0000_0002);
      chk("w1_k5_dack", 64'(bus1.d_ack), 64'd0);
      bus1.i_req = 1'b0;
      repeat (2) begin
         @(posedge clock); #1;
         chk("w1_quiet", 64'({bus1.busy, bus1.mem_cs, bus1.i_ack}), 64'd0);
      end

      chk("sb_drained_end", 64'(exp_q.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
